calendar_date_counter: RTL and testbench

// - Parametrised day/month/year calendar counter with full leap-year handling.
// - Generalises the 2-bit leap-cycle counter to a complete date register.
// - Advances on a one-cycle day tick and counts up or down.
// - Supports validated parallel load and wrap pulses.
// - Sits under the clock/alarm top level.
// - Feeds the BCD/7-segment display path; BCD conversion is external.

---
 rtl/cal_pkg.sv | 35 +++
 rtl/leap_year_detect.sv | 25 ++
 rtl/calendar_date_counter.sv | 161 ++++++++++++++++
 tb/tb_calendar_date_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cal_pkg.sv
// Shared calendar constants and the month-length helper used by the date
// counter and its load validation.
package cal_pkg;

  localparam int DAY_W   = 5;
  localparam int MONTH_W = 4;

  localparam logic [MONTH_W-1:0] JAN = 4'd1;
  localparam logic [MONTH_W-1:0] FEB = 4'd2;
  localparam logic [MONTH_W-1:0] MAR = 4'd3;
  localparam logic [MONTH_W-1:0] APR = 4'd4;
  localparam logic [MONTH_W-1:0] MAY = 4'd5;
  localparam logic [MONTH_W-1:0] JUN = 4'd6;
  localparam logic [MONTH_W-1:0] JUL = 4'd7;
  localparam logic [MONTH_W-1:0] AUG = 4'd8;
  localparam logic [MONTH_W-1:0] SEP = 4'd9;
  localparam logic [MONTH_W-1:0] OCT = 4'd10;
  localparam logic [MONTH_W-1:0] NOV = 4'd11;
  localparam logic [MONTH_W-1:0] DEC = 4'd12;

  // Returns 0 for an out-of-range month so a load with a bad month can never
  // satisfy day <= days_in_month.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                     input logic               leap);
    logic [DAY_W-1:0] dim;
    case (month)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: dim = 5'd31;
      APR, JUN, SEP, NOV:                dim = 5'd30;
      FEB:                               dim = leap ? 5'd29 : 5'd28;
      default:                           dim = 5'd0;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Combinational leap-year test. The modulus operators map to constant-divisor
// logic; no iterative divider is involved.
module leap_year_detect #(
  parameter int YEAR_W    = 14,
  parameter int GREGORIAN = 1
) (
  input  logic [YEAR_W-1:0] year,
  output logic              leap
);

  localparam logic [YEAR_W-1:0] C100 = YEAR_W'(100);
  localparam logic [YEAR_W-1:0] C400 = YEAR_W'(400);

  logic div4;
  logic div100;
  logic div400;

  assign div4   = (year[1:0] == 2'b00);
  assign div100 = ((year % C100) == '0);
  assign div400 = ((year % C400) == '0);

  // Julian mode ignores the century exceptions.
  assign leap = (GREGORIAN != 0) ? (div4 && (!div100 || div400)) : div4;

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year calendar register. Advances one day per en tick in either
// direction, accepts validated parallel loads and emits registered wrap and
// load-error pulses aligned with the new date.
module calendar_date_counter
  import cal_pkg::*;
#(
  parameter int YEAR_W    = 14,
  parameter int YEAR_MAX  = 9999,
  parameter int YEAR_INIT = 2000,
  parameter int GREGORIAN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [4:0]        load_day,
  input  logic [3:0]        load_month,
  input  logic [YEAR_W-1:0] load_year,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic              leap,
  output logic [1:0]        leap_phase,
  output logic              month_wrap,
  output logic              year_wrap,
  output logic              load_err
);

  localparam logic [YEAR_W-1:0] YMAX   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W:0]   YMAX_X = (YEAR_W+1)'(YEAR_MAX);
  localparam logic [YEAR_W:0]   ONE_X  = (YEAR_W+1)'(1);

  logic [DAY_W-1:0]   day_q, day_d;
  logic [MONTH_W-1:0] month_q, month_d;
  logic [YEAR_W-1:0]  year_q, year_d;
  logic               month_wrap_q, month_wrap_d;
  logic               year_wrap_q, year_wrap_d;
  logic               load_err_q, load_err_d;

  logic [YEAR_W:0]    yr_inc_x, yr_dec_x;
  logic               yr_inc_wrap, yr_dec_wrap;
  logic [YEAR_W-1:0]  yr_inc, yr_dec, year_step;
  logic               leap_cur, leap_step, leap_load;
  logic [MONTH_W-1:0] prev_month;
  logic [DAY_W-1:0]   dim_cur, dim_prev;
  logic               load_ok;

  // Year neighbours are formed one bit wider so the wrap compare sees the
  // true overflow/underflow rather than a truncated value.
  assign yr_inc_x    = {1'b0, year_q} + ONE_X;
  assign yr_inc_wrap = (yr_inc_x > YMAX_X);
  assign yr_inc      = yr_inc_wrap ? '0 : yr_inc_x[YEAR_W-1:0];
  assign yr_dec_x    = {1'b0, year_q} - ONE_X;
  assign yr_dec_wrap = yr_dec_x[YEAR_W];
  assign yr_dec      = yr_dec_wrap ? YMAX : yr_dec_x[YEAR_W-1:0];
  assign year_step   = dir ? yr_dec : yr_inc;

  leap_year_detect #(.YEAR_W(YEAR_W), .GREGORIAN(GREGORIAN)) u_leap_cur (
    .year (year_q),
    .leap (leap_cur)
  );

  leap_year_detect #(.YEAR_W(YEAR_W), .GREGORIAN(GREGORIAN)) u_leap_step (
    .year (year_step),
    .leap (leap_step)
  );

  leap_year_detect #(.YEAR_W(YEAR_W), .GREGORIAN(GREGORIAN)) u_leap_load (
    .year (load_year),
    .leap (leap_load)
  );

  // Month lengths for the current month and for the month a down-step lands in;
  // the latter takes the destination year's leap flag when crossing into December.
  assign prev_month = (month_q == JAN) ? DEC : (month_q - 4'd1);
  assign dim_cur    = days_in_month(month_q, leap_cur);
  assign dim_prev   = days_in_month(prev_month, (month_q == JAN) ? leap_step : leap_cur);

  assign load_ok = (load_month >= JAN) && (load_month <= DEC) &&
                   (load_day != '0) &&
                   (load_day <= days_in_month(load_month, leap_load)) &&
                   ({1'b0, load_year} <= YMAX_X);

  // Next-date and pulse logic: load takes priority over en, and any load
  // request (valid or not) discards the tick.
  always_comb begin
    day_d        = day_q;
    month_d      = month_q;
    year_d       = year_q;
    month_wrap_d = 1'b0;
    year_wrap_d  = 1'b0;
    load_err_d   = 1'b0;
    if (load) begin
      if (load_ok) begin
        day_d   = load_day;
        month_d = load_month;
        year_d  = load_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (!dir) begin
        if (day_q < dim_cur) begin
          day_d = day_q + 5'd1;
        end else begin
          day_d        = 5'd1;
          month_wrap_d = 1'b1;
          if (month_q == DEC) begin
            month_d     = JAN;
            year_d      = yr_inc;
            year_wrap_d = yr_inc_wrap;
          end else begin
            month_d = month_q + 4'd1;
          end
        end
      end else begin
        if (day_q > 5'd1) begin
          day_d = day_q - 5'd1;
        end else begin
          month_wrap_d = 1'b1;
          month_d      = prev_month;
          day_d        = dim_prev;
          if (month_q == JAN) begin
            year_d      = yr_dec;
            year_wrap_d = yr_dec_wrap;
          end
        end
      end
    end
  end

  // Date and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      day_q        <= 5'd1;
      month_q      <= JAN;
      year_q       <= YEAR_W'(YEAR_INIT);
      month_wrap_q <= 1'b0;
      year_wrap_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      day_q        <= day_d;
      month_q      <= month_d;
      year_q       <= year_d;
      month_wrap_q <= month_wrap_d;
      year_wrap_q  <= year_wrap_d;
      load_err_q   <= load_err_d;
    end
  end

  assign day        = day_q;
  assign month      = month_q;
  assign year       = year_q;
  assign leap       = leap_cur;
  assign leap_phase = year_q[1:0];
  assign month_wrap = month_wrap_q;
  assign year_wrap  = year_wrap_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter: directed scenarios plus a
// randomized run, all compared against a date-arithmetic reference model.
module tb_calendar_date_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [4:0]  load_day = 5'd0;
  logic [3:0]  load_month = 4'd0;
  logic [13:0] load_year = 14'd0;

  logic [4:0]  day, j_day;
  logic [3:0]  month, j_month;
  logic [13:0] year, j_year;
  logic        leap, j_leap;
  logic [1:0]  leap_phase, j_leap_phase;
  logic        month_wrap, j_month_wrap;
  logic        year_wrap, j_year_wrap;
  logic        load_err, j_load_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int md = 1, mm = 1, my = 2000;
  bit emw = 0, eyw = 0, ele = 0;

  always #5 clk = ~clk;

  calendar_date_counter #(.YEAR_W(14), .YEAR_MAX(9999), .YEAR_INIT(2000), .GREGORIAN(1)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .day(day), .month(month), .year(year), .leap(leap), .leap_phase(leap_phase),
    .month_wrap(month_wrap), .year_wrap(year_wrap), .load_err(load_err)
  );

  calendar_date_counter #(.YEAR_W(14), .YEAR_MAX(9999), .YEAR_INIT(2000), .GREGORIAN(0)) dut_j (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_day(load_day), .load_month(load_month), .load_year(load_year),
    .day(j_day), .month(j_month), .year(j_year), .leap(j_leap), .leap_phase(j_leap_phase),
    .month_wrap(j_month_wrap), .year_wrap(j_year_wrap), .load_err(j_load_err)
  );

  function automatic bit m_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int m_dim(int m, int y);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (m == 2 && m_leap(y)) return 29;
    return t[m-1];
  endfunction

  function automatic logic [28:0] obs();
    return {year, month, day, leap, leap_phase, month_wrap, year_wrap, load_err};
  endfunction

  function automatic logic [28:0] expv();
    return {14'(my), 4'(mm), 5'(md), logic'(m_leap(my)), 2'(my % 4), logic'(emw), logic'(eyw), logic'(ele)};
  endfunction

  function automatic string fmt(logic [28:0] v);
    return $sformatf("%0d-%0d-%0d leap=%0b ph=%0d mw=%0b yw=%0b le=%0b",
                     v[28:15], v[14:11], v[10:6], v[5], v[4:3], v[2], v[1], v[0]);
  endfunction

  // Drive one cycle of inputs, clock it, then advance the reference model.
  task automatic cycle(bit r, bit e, bit d, bit l, int ld, int lm, int ly);
    bit valid;
    rst = r; en = e; dir = d; load = l;
    load_day = 5'(ld); load_month = 4'(lm); load_year = 14'(ly);
    @(posedge clk);
    #1;
    ld = int'(load_day); lm = int'(load_month); ly = int'(load_year);
    emw = 0; eyw = 0; ele = 0;
    if (r) begin
      md = 1; mm = 1; my = 2000;
    end else if (l) begin
      valid = (lm >= 1) && (lm <= 12) && (ly <= 9999) && (ld >= 1) && (ld <= m_dim(lm, ly));
      if (valid) begin md = ld; mm = lm; my = ly; end
      else ele = 1;
    end else if (e && !d) begin
      if (md < m_dim(mm, my)) md++;
      else begin
        md = 1; emw = 1;
        if (mm == 12) begin
          mm = 1;
          if (my == 9999) begin my = 0; eyw = 1; end else my++;
        end else mm++;
      end
    end else if (e && d) begin
      if (md > 1) md--;
      else begin
        emw = 1;
        if (mm == 1) begin
          mm = 12;
          if (my == 0) begin my = 9999; eyw = 1; end else my--;
        end else mm--;
        md = m_dim(mm, my);
      end
    end
    rst = 0; en = 0; load = 0;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd2000, 4'd1, 5'd1, 1'b1, 2'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset: got %s want 2000-1-1 leap=1 ph=0 pulses=0", fmt(obs()));
    end
  endtask

  task automatic test_month_up();
    cycle(0, 0, 0, 1, 28, 2, 2023);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd2023, 4'd3, 5'd1, 1'b0, 2'd3, 3'b100}) begin
      n_fail++; $display("FAIL feb28_2023_up: got %s want 2023-3-1 mw=1", fmt(obs()));
    end
    cycle(0, 0, 0, 1, 28, 2, 2024);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL feb28_2024_up: got %s want %s", fmt(obs()), fmt(expv()));
    end
  endtask

  task automatic test_century();
    cycle(0, 0, 0, 1, 28, 2, 1900);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd1900, 4'd3, 5'd1, 1'b0, 2'd0, 3'b100}) begin
      n_fail++; $display("FAIL century_1900: got %s want 1900-3-1 leap=0", fmt(obs()));
    end
    n_checks++;
    if ({j_year, j_month, j_day, j_leap} !== {14'd1900, 4'd2, 5'd29, 1'b1}) begin
      n_fail++;
      $display("FAIL julian_1900: got %0d-%0d-%0d leap=%0b want 1900-2-29 leap=1",
               j_year, j_month, j_day, j_leap);
    end
    cycle(0, 0, 0, 1, 28, 2, 2000);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL century_2000: got %s want %s", fmt(obs()), fmt(expv()));
    end
  endtask

  task automatic test_year_wrap();
    cycle(0, 0, 0, 1, 31, 12, 9999);
    cycle(0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd0, 4'd1, 5'd1, 1'b1, 2'd0, 3'b110}) begin
      n_fail++; $display("FAIL wrap_up: got %s want 0-1-1 mw=1 yw=1", fmt(obs()));
    end
    cycle(0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd9999, 4'd12, 5'd31, 1'b0, 2'd3, 3'b110}) begin
      n_fail++; $display("FAIL wrap_down: got %s want 9999-12-31 mw=1 yw=1", fmt(obs()));
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL pulse_clear: got %s want %s", fmt(obs()), fmt(expv()));
    end
  endtask

  task automatic test_down_leap();
    cycle(0, 0, 0, 1, 1, 3, 2024);
    cycle(0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== {14'd2024, 4'd2, 5'd29, 1'b1, 2'd0, 3'b100}) begin
      n_fail++; $display("FAIL down_2024: got %s want 2024-2-29 mw=1", fmt(obs()));
    end
    cycle(0, 0, 0, 1, 1, 3, 2023);
    cycle(0, 1, 1, 0, 0, 0, 0);
    n_checks++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL down_2023: got %s want %s", fmt(obs()), fmt(expv()));
    end
  endtask

  task automatic test_load_checks();
    int bad[4][3] = '{'{29, 2, 2023}, '{1, 13, 2023}, '{0, 5, 2023}, '{1, 1, 10000}};
    cycle(0, 0, 0, 1, 15, 6, 2022);
    for (int i = 0; i < 4; i++) begin
      cycle(0, i % 2, 0, 1, bad[i][0], bad[i][1], bad[i][2]);
      n_checks++;
      if (obs() !== expv() || load_err !== 1'b1) begin
        n_fail++; $display("FAIL load_invalid_%0d: got %s want %s", i, fmt(obs()), fmt(expv()));
      end
    end
    cycle(0, 1, 0, 1, 29, 2, 2024);
    n_checks++;
    if (obs() !== {14'd2024, 4'd2, 5'd29, 1'b1, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL load_with_en: got %s want 2024-2-29 no pulses", fmt(obs()));
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 1, 31, 12, 9999);
    cycle(1, 1, 0, 1, 10, 10, 1234);
    n_checks++;
    if (obs() !== {14'd2000, 4'd1, 5'd1, 1'b1, 2'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_with_load: got %s want 2000-1-1 pulses=0", fmt(obs()));
    end
  endtask

  task automatic test_random();
    int years[8] = '{0, 1, 1900, 2000, 2023, 2024, 9998, 9999};
    int ly;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        cycle(1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 1, 1);
      end else if ($urandom_range(0, 9) == 0) begin
        ly = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9990, 16383)) : years[$urandom_range(0, 7)];
        cycle(0, 1'($urandom), 1'($urandom), 1, $urandom_range(0, 31), $urandom_range(0, 15), ly);
      end else begin
        cycle(0, $urandom_range(0, 3) != 0, 1'($urandom), 0, 0, 0, 0);
      end
      n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_%0d: got %s want %s", i, fmt(obs()), fmt(expv()));
      end
    end
  endtask

  initial begin
    test_reset();
    test_month_up();
    test_century();
    test_year_wrap();
    test_down_leap();
    test_load_checks();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
